// File: rtl/l1_servo_pkg.sv
// Shared state encoding and saturating threshold arithmetic for the L1 threshold servo.
package l1_servo_pkg;

   localparam int unsigned STEP_BITS = 8;

   typedef enum logic [2:0] {
      StIdle,
      StInit,
      StCount,
      StAdjust,
      StLoad,
      StCommit
   } servo_state_t;

   // Operands are at most 31 bits wide, so the 33-bit sum cannot overflow; lim is the ceiling.
   function automatic logic [31:0] sat_adj(input logic [31:0] thr, input logic [31:0] step,
                                           input logic up, input logic down,
                                           input logic [31:0] lim);
      logic [32:0] sum;
      logic [31:0] res;
      res = thr;
      sum = {1'b0, thr} + {1'b0, step};
      if (up) begin
         res = (sum > {1'b0, lim}) ? lim : sum[31:0];
      end else if (down) begin
         res = (step > thr) ? 32'd0 : thr - step;
      end
      return res;
   endfunction

endpackage

// File: rtl/l1_sat_counter.sv
// Per-beam trigger counter that sticks at all-ones instead of wrapping.
module l1_sat_counter #(
   parameter int unsigned COUNT_BITS = 16
) (
   input  logic                  aclk,
   input  logic                  aresetn,
   input  logic                  i_clear,
   input  logic                  i_inc,
   output logic [COUNT_BITS-1:0] o_count
);

   logic [COUNT_BITS-1:0] r_count;

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_inc && (r_count != '1)) begin
         r_count <= r_count + COUNT_BITS'(1);
      end
   end

   assign o_count = r_count;

endmodule

// File: rtl/l1_thresh_servo.sv
// Closed-loop per-beam threshold servo: counts triggers over an interval, nudges each
// threshold toward the target rate, then streams the new thresholds into the beamformer.
module l1_thresh_servo
   import l1_servo_pkg::*;
#(
   parameter int unsigned NBEAMS      = 2,
   parameter int unsigned THRESH_BITS = 18,
   parameter int unsigned COUNT_BITS  = 16,
   parameter int unsigned PERIOD_BITS = 24
) (
   input  logic                   aclk,
   input  logic                   aresetn,
   input  logic                   enable_i,
   input  logic [PERIOD_BITS-1:0] period_i,
   input  logic [COUNT_BITS-1:0]  target_i,
   input  logic [STEP_BITS-1:0]   step_i,
   input  logic [THRESH_BITS-1:0] thresh_init_i,
   input  logic [NBEAMS-1:0]      trigger_i,
   output logic [THRESH_BITS-1:0] thresh_o,
   output logic [NBEAMS-1:0]      thresh_ce_o,
   output logic                   update_o,
   output logic                   interval_done_o,
   output logic                   busy_o
);

   localparam int unsigned IDX_W      = (NBEAMS > 1) ? $clog2(NBEAMS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBEAMS - 1);
   localparam logic [31:0] THR_MAX    = 32'({THRESH_BITS{1'b1}});

   servo_state_t           r_state;
   logic [IDX_W-1:0]       r_idx;
   logic [PERIOD_BITS-1:0] r_timer;
   logic [THRESH_BITS-1:0] r_thr [NBEAMS];
   logic [THRESH_BITS-1:0] r_thresh;
   logic [NBEAMS-1:0]      r_ce;
   logic                   r_update;
   logic                   r_done;

   logic [COUNT_BITS-1:0]  w_cnt [NBEAMS];
   logic [COUNT_BITS-1:0]  w_cnt_sel;
   logic [PERIOD_BITS-1:0] w_period_m1;
   logic                   w_last;
   logic                   w_clear;
   logic                   w_counting;
   logic [THRESH_BITS-1:0] w_thr_adj;

   assign w_clear    = (r_state == StInit) || (r_state == StCommit);
   assign w_counting = (r_state == StCount);

   for (genvar b = 0; b < NBEAMS; b++) begin : g_cnt
      l1_sat_counter #(
         .COUNT_BITS (COUNT_BITS)
      ) u_cnt (
         .aclk    (aclk),
         .aresetn (aresetn),
         .i_clear (w_clear),
         .i_inc   (w_counting && trigger_i[b]),
         .o_count (w_cnt[b])
      );
   end

   // A programmed period of 0 behaves as a 1-cycle interval.
   assign w_period_m1 = (period_i == '0) ? '0 : period_i - PERIOD_BITS'(1);
   assign w_last      = (r_timer == w_period_m1);

   assign w_cnt_sel = w_cnt[r_idx];
   assign w_thr_adj = THRESH_BITS'(sat_adj(32'(r_thr[r_idx]), 32'(step_i),
                                           w_cnt_sel > target_i, w_cnt_sel < target_i,
                                           THR_MAX));

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         r_state  <= StIdle;
         r_idx    <= '0;
         r_timer  <= '0;
         r_thresh <= '0;
         r_ce     <= '0;
         r_update <= 1'b0;
         r_done   <= 1'b0;
         for (int b = 0; b < NBEAMS; b++) r_thr[b] <= '0;
      end else begin
         r_ce     <= '0;
         r_update <= 1'b0;
         r_done   <= 1'b0;
         unique case (r_state)
            StIdle: begin
               if (enable_i) r_state <= StInit;
            end
            StInit: begin
               for (int b = 0; b < NBEAMS; b++) r_thr[b] <= thresh_init_i;
               r_idx   <= '0;
               r_timer <= '0;
               r_state <= StLoad;
            end
            StCount: begin
               if (!enable_i) begin
                  r_state <= StIdle;
               end else if (w_last) begin
                  r_idx   <= '0;
                  r_state <= StAdjust;
               end else begin
                  r_timer <= r_timer + PERIOD_BITS'(1);
               end
            end
            StAdjust: begin
               r_thr[r_idx] <= w_thr_adj;
               if (r_idx == LAST_IDX) begin
                  r_idx   <= '0;
                  r_state <= StLoad;
               end else begin
                  r_idx <= r_idx + IDX_W'(1);
               end
            end
            StLoad: begin
               r_thresh <= r_thr[r_idx];
               r_ce     <= NBEAMS'(1) << r_idx;
               if (r_idx == LAST_IDX) begin
                  r_idx   <= '0;
                  r_state <= StCommit;
               end else begin
                  r_idx <= r_idx + IDX_W'(1);
               end
            end
            StCommit: begin
               r_update <= 1'b1;
               r_done   <= 1'b1;
               r_timer  <= '0;
               r_state  <= enable_i ? StCount : StIdle;
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign thresh_o        = r_thresh;
   assign thresh_ce_o     = r_ce;
   assign update_o        = r_update;
   assign interval_done_o = r_done;
   assign busy_o          = (r_state != StIdle);

endmodule

// File: tb/tb_l1_thresh_servo.sv
// Directed bench for l1_thresh_servo: an event-queue model checked every cycle plus
// hand-computed expectations for loaded thresholds, latencies and reset behaviour.
module tb_l1_thresh_servo;

   localparam int NB   = 2;
   localparam int TMAX = 262143;
   localparam int CMAX = 65535;

   logic        aclk = 1'b0;
   logic        aresetn;
   logic        enable_i;
   logic [23:0] period_i;
   logic [15:0] target_i;
   logic [7:0]  step_i;
   logic [17:0] thresh_init_i;
   logic [1:0]  trigger_i;
   logic [17:0] thresh_o;
   logic [1:0]  thresh_ce_o;
   logic        update_o;
   logic        interval_done_o;
   logic        busy_o;

   int n_vec = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   always #5 aclk = ~aclk;

   l1_thresh_servo #(
      .NBEAMS      (2),
      .THRESH_BITS (18),
      .COUNT_BITS  (16),
      .PERIOD_BITS (24)
   ) dut (
      .aclk            (aclk),
      .aresetn         (aresetn),
      .enable_i        (enable_i),
      .period_i        (period_i),
      .target_i        (target_i),
      .step_i          (step_i),
      .thresh_init_i   (thresh_init_i),
      .trigger_i       (trigger_i),
      .thresh_o        (thresh_o),
      .thresh_ce_o     (thresh_ce_o),
      .update_o        (update_o),
      .interval_done_o (interval_done_o),
      .busy_o          (busy_o)
   );

   // Model: while counting it accumulates per-beam totals; at the end of a window (or on
   // start-up) it schedules the whole dead-time output sequence as a queue of cycles.
   typedef struct {
      int ce;
      int thr;
      bit commit;
   } slot_t;

   slot_t       mq[$];
   bit          m_run = 1'b0;
   bit          m_counting = 1'b0;
   int          m_timer = 0;
   int          m_cnt[NB];
   int          m_thr[NB];
   logic [17:0] e_thresh = '0;
   logic [1:0]  e_ce = '0;
   logic        e_upd = 1'b0;
   logic        e_done = 1'b0;
   logic        e_busy = 1'b0;

   initial begin
      slot_t s;
      int    last;
      forever begin
         @(posedge aclk);
         e_ce   = '0;
         e_upd  = 1'b0;
         e_done = 1'b0;
         if (!aresetn) begin
            mq.delete();
            m_run      = 1'b0;
            m_counting = 1'b0;
            m_timer    = 0;
            e_thresh   = '0;
            for (int b = 0; b < NB; b++) begin
               m_thr[b] = 0;
               m_cnt[b] = 0;
            end
         end else if (mq.size() > 0) begin
            s = mq.pop_front();
            if (s.ce != 0) begin
               e_ce     = 2'(s.ce);
               e_thresh = 18'(s.thr);
            end
            if (s.commit) begin
               e_upd      = 1'b1;
               e_done     = 1'b1;
               m_timer    = 0;
               m_counting = enable_i;
               m_run      = enable_i;
               for (int b = 0; b < NB; b++) m_cnt[b] = 0;
            end
         end else if (m_counting) begin
            if (!enable_i) begin
               m_counting = 1'b0;
               m_run      = 1'b0;
            end else begin
               for (int b = 0; b < NB; b++)
                  if (trigger_i[b]) m_cnt[b] = (m_cnt[b] == CMAX) ? CMAX : m_cnt[b] + 1;
               last = (period_i == 0) ? 0 : int'(period_i) - 1;
               if (m_timer == last) begin
                  for (int b = 0; b < NB; b++) begin
                     if (m_cnt[b] > int'(target_i))
                        m_thr[b] = (m_thr[b] + int'(step_i) > TMAX) ? TMAX
                                   : m_thr[b] + int'(step_i);
                     else if (m_cnt[b] < int'(target_i))
                        m_thr[b] = (m_thr[b] < int'(step_i)) ? 0 : m_thr[b] - int'(step_i);
                  end
                  mq.push_back('{0, 0, 1'b0});
                  mq.push_back('{0, 0, 1'b0});
                  mq.push_back('{1, m_thr[0], 1'b0});
                  mq.push_back('{2, m_thr[1], 1'b0});
                  mq.push_back('{0, 0, 1'b1});
                  m_counting = 1'b0;
               end else begin
                  m_timer++;
               end
            end
         end else if (!m_run && enable_i) begin
            m_run   = 1'b1;
            m_timer = 0;
            for (int b = 0; b < NB; b++) begin
               m_thr[b] = int'(thresh_init_i);
               m_cnt[b] = 0;
            end
            mq.push_back('{0, 0, 1'b0});
            mq.push_back('{1, m_thr[0], 1'b0});
            mq.push_back('{2, m_thr[1], 1'b0});
            mq.push_back('{0, 0, 1'b1});
         end
         e_busy = m_run;
      end
   end

   int ld0 = -1;
   int ld1 = -1;

   initial begin
      forever begin
         @(negedge aclk);
         if (chk_en) begin
            n_vec++;
            if ({thresh_o, thresh_ce_o, update_o, interval_done_o, busy_o} !==
                {e_thresh, e_ce, e_upd, e_done, e_busy}) begin
               n_err++;
               $display("FAIL cycle @%0t: got thr=%0d ce=%b upd=%b done=%b busy=%b, want thr=%0d ce=%b upd=%b done=%b busy=%b",
                        $time, thresh_o, thresh_ce_o, update_o, interval_done_o, busy_o,
                        e_thresh, e_ce, e_upd, e_done, e_busy);
            end
            if (thresh_ce_o[0] === 1'b1) ld0 = int'(thresh_o);
            if (thresh_ce_o[1] === 1'b1) ld1 = int'(thresh_o);
         end
      end
   end

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge aclk);
      #1;
   endtask

   // Advances at least one cycle and stops on the first cycle showing update_o.
   task automatic wait_update(input string name, output int k);
      k = 0;
      do begin
         tick(1);
         k++;
      end while (update_o !== 1'b1 && k < 200);
      if (update_o !== 1'b1) check({name, " update timeout"}, 0, 1);
   endtask

   task automatic wait_ce0(input string name);
      int k = 0;
      while (thresh_ce_o !== 2'b01 && k < 20) begin
         tick(1);
         k++;
      end
      if (thresh_ce_o !== 2'b01) check({name, " ce=01 timeout"}, int'(thresh_ce_o), 1);
   endtask

   task automatic interval(input int n0, input int n1, input int len);
      for (int i = 0; i < len; i++) begin
         trigger_i = {1'(i < n1), 1'(i < n0)};
         tick(1);
      end
      trigger_i = '0;
   endtask

   initial begin
      int k;
      aresetn       = 1'b0;
      enable_i      = 1'b0;
      period_i      = 24'd100;
      target_i      = 16'd10;
      step_i        = 8'd5;
      thresh_init_i = 18'd1000;
      trigger_i     = '0;
      tick(1);
      chk_en = 1'b1;
      tick(2);
      check("reset thresh_o", int'(thresh_o), 0);
      check("reset ce", int'(thresh_ce_o), 0);
      check("reset update", int'(update_o), 0);
      check("reset done", int'(interval_done_o), 0);
      check("reset busy", int'(busy_o), 0);

      aresetn = 1'b1;
      tick(1);
      enable_i = 1'b1;
      tick(3);
      check("init ce beam0", int'(thresh_ce_o), 1);
      check("init thr beam0", int'(thresh_o), 1000);
      tick(1);
      check("init ce beam1", int'(thresh_ce_o), 2);
      check("init thr beam1", int'(thresh_o), 1000);
      tick(1);
      check("init update", int'(update_o), 1);

      interval(20, 3, 100);
      wait_update("servo dir", k);
      check("servo dir thr0", ld0, 1005);
      check("servo dir thr1", ld1, 995);

      interval(10, 0, 100);
      wait_update("equal", k);
      check("equal thr0", ld0, 1005);
      check("equal thr1", ld1, 990);

      period_i  = 24'd0;
      trigger_i = 2'b01;
      wait_update("period0", k);
      trigger_i = '0;
      period_i  = 24'd100;
      check("period0 cycle length", k, 6);
      check("period0 thr0", ld0, 1000);
      check("period0 thr1", ld1, 985);

      tick(10);
      enable_i = 1'b0;
      tick(2);
      check("count drop busy", int'(busy_o), 0);
      tick(5);

      thresh_init_i = 18'd262141;
      enable_i      = 1'b1;
      wait_update("sat init", k);
      check("sat init latency", k, 5);
      check("sat init thr0", ld0, 262141);
      interval(20, 0, 100);
      wait_update("sat up", k);
      check("sat up thr0", ld0, 262143);
      check("sat up thr1", ld1, 262136);

      interval(20, 20, 100);
      wait_ce0("load drop");
      enable_i = 1'b0;
      wait_update("load drop", k);
      check("load drop thr0", ld0, 262143);
      check("load drop thr1", ld1, 262141);
      check("load drop busy", int'(busy_o), 0);
      tick(3);

      thresh_init_i = 18'd2;
      enable_i      = 1'b1;
      wait_update("low init", k);
      check("low init thr0", ld0, 2);
      interval(0, 0, 100);
      wait_update("sat down", k);
      check("sat down thr0", ld0, 0);
      check("sat down thr1", ld1, 0);

      // 70000 triggers wrap to 4464 < 60000 unless the counter sticks at 65535.
      period_i = 24'd70000;
      target_i = 16'd60000;
      interval(70000, 70000, 70000);
      wait_update("cnt sat", k);
      check("cnt sat thr0", ld0, 5);
      check("cnt sat thr1", ld1, 5);
      target_i = 16'd10;
      period_i = 24'd10;

      interval(0, 0, 10);
      wait_ce0("mid-load reset");
      aresetn  = 1'b0;
      enable_i = 1'b0;
      tick(1);
      check("mid-load reset thr", int'(thresh_o), 0);
      check("mid-load reset ce", int'(thresh_ce_o), 0);
      check("mid-load reset update", int'(update_o), 0);
      check("mid-load reset busy", int'(busy_o), 0);
      tick(3);
      aresetn = 1'b1;
      tick(4);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
